// File: rtl/clock_time_counter.sv
// 24-hour BCD time-of-day counter with a 1 s prescaler and a set mode for
// stepping hours and minutes; feeds the per-digit seven-segment decoders.
module clock_time_counter #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_tick,
  output logic       colon
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc;

  logic       min_wrap;
  logic [2:0] min_inc_tens;
  logic [3:0] min_inc_units;
  logic [1:0] hr_inc_tens;
  logic [3:0] hr_inc_units;

  assign sec_tick = !set_mode && (presc == LAST);
  assign colon    = set_mode || (presc < HALF);

  // Next-value of minutes and hours when each is stepped by one, shared by
  // the run-mode carry chain and the set-mode increment buttons.
  assign min_wrap      = (min_tens == 3'd5) && (min_units == 4'd9);
  assign min_inc_units = (min_units == 4'd9) ? 4'd0 : min_units + 4'd1;
  assign min_inc_tens  = (min_units != 4'd9) ? min_tens :
                         (min_tens == 3'd5)  ? 3'd0 : min_tens + 3'd1;

  assign hr_inc_units = ((hr_tens == 2'd2) && (hr_units == 4'd3)) ? 4'd0 :
                        (hr_units == 4'd9) ? 4'd0 : hr_units + 4'd1;
  assign hr_inc_tens  = ((hr_tens == 2'd2) && (hr_units == 4'd3)) ? 2'd0 :
                        (hr_units == 4'd9) ? hr_tens + 2'd1 : hr_tens;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      hr_tens   <= 2'd0;
      hr_units  <= 4'd0;
      min_tens  <= 3'd0;
      min_units <= 4'd0;
      sec_tens  <= 3'd0;
      sec_units <= 4'd0;
    end else if (set_mode) begin
      presc <= '0;
      // Minute stepping never carries into hours and restarts the minute.
      if (inc_min) begin
        min_tens  <= min_inc_tens;
        min_units <= min_inc_units;
        sec_tens  <= 3'd0;
        sec_units <= 4'd0;
      end
      if (inc_hr) begin
        hr_tens  <= hr_inc_tens;
        hr_units <= hr_inc_units;
      end
    end else begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
      if (sec_tick) begin
        if (sec_units == 4'd9) begin
          sec_units <= 4'd0;
          if (sec_tens == 3'd5) begin
            sec_tens  <= 3'd0;
            min_tens  <= min_inc_tens;
            min_units <= min_inc_units;
            if (min_wrap) begin
              hr_tens  <= hr_inc_tens;
              hr_units <= hr_inc_units;
            end
          end else begin
            sec_tens <= sec_tens + 3'd1;
          end
        end else begin
          sec_units <= sec_units + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter: directed scenarios plus random
// stimulus compared every cycle against a seconds-of-day reference model.
module tb_clock_time_counter;

  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_mode;
  logic       inc_hr;
  logic       inc_min;
  logic [1:0] hr_tens;
  logic [3:0] hr_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       sec_tick;
  logic       colon;

  int checkCount = 0;
  int failCount  = 0;

  // Reference state: time as seconds since midnight plus prescaler phase.
  int modelTime  = 0;
  int modelPresc = 0;

  clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .inc_hr(inc_hr),
    .inc_min(inc_min), .hr_tens(hr_tens), .hr_units(hr_units),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .sec_tick(sec_tick), .colon(colon)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] bcdOf(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return ((h / 10) << 18) | ((h % 10) << 14) | ((m / 10) << 11) |
           ((m % 10) << 7) | ((s / 10) << 4) | (s % 10);
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model across the edge, then check the registered digits.
  task automatic applyStimulus(input logic r, input logic sm, input logic ih,
                               input logic im);
    int h, m, s;
    rst = r; set_mode = sm; inc_hr = ih; inc_min = im;
    #1;
    checkOutput("sec_tick", 32'(sec_tick), 32'(!sm && modelPresc == CLK_HZ - 1));
    checkOutput("colon", 32'(colon), 32'(sm || modelPresc < CLK_HZ / 2));
    @(posedge clk);
    if (r) begin
      modelTime = 0;
      modelPresc = 0;
    end else if (sm) begin
      modelPresc = 0;
      h = modelTime / 3600;
      m = (modelTime / 60) % 60;
      s = modelTime % 60;
      if (im) begin
        m = (m + 1) % 60;
        s = 0;
      end
      if (ih) h = (h + 1) % 24;
      modelTime = h * 3600 + m * 60 + s;
    end else begin
      if (modelPresc == CLK_HZ - 1) modelTime = (modelTime + 1) % 86400;
      modelPresc = (modelPresc + 1) % CLK_HZ;
    end
    #1;
    checkOutput("time", {12'd0, hr_tens, hr_units, min_tens, min_units,
                         sec_tens, sec_units}, bcdOf(modelTime));
    checkOutput("hr_tens_range", 32'(hr_tens <= 2'd2), 32'd1);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset, then step to hh:mm:00 in set mode; leaves set_mode asserted.
  task automatic setTo(input int h, input int m);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < h; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < m; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic sm;
    rst = 1'b1; set_mode = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_time", {12'd0, hr_tens, hr_units, min_tens, min_units,
                               sec_tens, sec_units}, 32'd0);
    checkOutput("reset_colon", 32'(colon), 32'd1);

    $display("[TB] Basic run from reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runCycles(12);

    $display("[TB] Set to 23:59:00 and roll over midnight");
    setTo(23, 59);
    runCycles(61 * CLK_HZ);

    $display("[TB] Hour stepping through 09, 10, 19, 20, 23, 00");
    setTo(8, 0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] Minute stepping without hour carry");
    setTo(12, 59);
    runCycles(30 * CLK_HZ);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] Increment pulses ignored in run mode");
    setTo(0, 0);
    runCycles(5 * CLK_HZ + 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(2 * CLK_HZ);

    $display("[TB] Reset mid-second at 17:42:33");
    setTo(17, 42);
    runCycles(33 * CLK_HZ + 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runCycles(2 * CLK_HZ);

    $display("[TB] Random stimulus");
    sm = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) sm = ~sm;
      applyStimulus($urandom_range(0, 199) == 0, sm,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- 24-hour BCD time-of-day counter (HH:MM:SS) for the digital clock, with an internal prescaler that turns the system clock into 1 s ticks.
- Sits directly upstream of the per-digit seven-segment decoders.
- hr_tens is 2 bits wide and carries only 0..2, the range the hour-tens decoder accepts.
- Includes a set mode that halts timekeeping and lets the user step hours and minutes.

Parameters:
CLK_HZ, 100000000, system clock cycles per second; legal range >= 2 (benches use 4).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
set_mode  input  1  1 = halt timekeeping and accept inc_hr/inc_min; 0 = run.
inc_hr  input  1  single-cycle pulse (debounced upstream): hours +1.
inc_min  input  1  single-cycle pulse (debounced upstream): minutes +1.
hr_tens  output  2  hour tens digit, 0..2.
hr_units  output  4  hour units digit, 0..9 (0..3 when hr_tens = 2).
min_tens  output  3  minute tens digit, 0..5.
min_units  output  4  minute units digit, 0..9.
sec_tens  output  3  second tens digit, 0..5.
sec_units  output  4  second units digit, 0..9.
sec_tick  output  1  one-cycle pulse on the cycle a second elapses.
colon  output  1  colon blink enable for the display.

Behaviour:
- Reset, sampled only on a clk edge:
  - All digits 0 (00:00:00); prescaler 0; sec_tick 0; colon 1.
  - Overrides every other input, including set_mode and the inc pulses.
- Prescaler (run mode, set_mode = 0):
  - Counts 0..CLK_HZ-1 and wraps to 0.
  - sec_tick is combinationally high while the prescaler = CLK_HZ-1.
  - With set_mode held 0 after reset, the first sec_tick is high in cycle CLK_HZ-1; the seconds value changes on the edge ending that cycle.
  - Result: 00:00:01 is visible CLK_HZ cycles after reset release.
- Digit outputs are registered; all digits update on the same edge, so no intermediate value (e.g. 00:00:60) is ever visible.
- Carry chain on a tick:
  - sec_units 9->0 carries into sec_tens; sec_tens 5->0 (59->00) carries into minutes.
  - min_units 9->0 carries into min_tens; min_tens 5->0 carries into hours.
  - Hours: units 9->0 with tens+1, except 23 -> 00 (hr_tens 2 and hr_units 3 wrap to 0 and 0).
  - 23:59:59 + tick -> 00:00:00, all in one edge.
- Set mode (set_mode = 1):
  - Prescaler held at 0; sec_tick forced 0; seconds held; colon forced 1.
  - inc_min: minutes +1 mod 60, no carry into hours (59 -> 00, hours unchanged); seconds cleared to 00.
  - inc_hr: hours +1 mod 24 (09 -> 10, 19 -> 20, 23 -> 00); minutes and seconds unchanged.
  - inc_hr and inc_min in the same cycle: both applied independently on that edge.
  - inc pulses while set_mode = 0 are ignored.
  - Leaving set mode (1 -> 0): prescaler restarts from 0; the next tick occurs CLK_HZ cycles later.
- Colon:
  - Run mode: colon = 1 while prescaler < CLK_HZ/2 (integer division), else 0.
  - Set mode: colon steady 1.
- Width rules:
  - Each digit is its own BCD counter; no binary-to-BCD conversion.
  - Illegal codes (hr_units > 9, min_tens > 5, etc.) are unreachable by construction; no recovery logic is required.
  - hr_tens is never 3.
- Reset asserted mid-operation (any mode, any count): next edge gives 00:00:00, prescaler 0.

Test Plan:
1. CLK_HZ=4: release rst, run 4 cycles -> sec_tick high in cycle 3; 00:00:01 visible from cycle 4; colon pattern 1,1,0,0 repeating.
2. Set mode: enter set_mode, inc_hr x23 and inc_min x59, exit, run 60 ticks -> time reads 23:59:59 after 59 ticks; next tick gives 00:00:00 in one edge with no intermediate value.
3. Hour stepping in set mode from 08 -> 09, 10, 19, 20, 23, 00: each inc_hr advances exactly one hour; hr_tens never exceeds 2.
4. Set mode at 12:59:30: inc_min -> 12:00:00 (no hour carry, seconds cleared); inc_hr+inc_min same cycle -> 13:01:00.
5. Run at 00:00:05 with set_mode=0: pulse inc_hr and inc_min -> no change; assert set_mode mid-second -> sec_tick never fires and colon = 1 while set_mode = 1.
6. Assert rst at 17:42:33 with prescaler = 2 -> next edge 00:00:00, prescaler 0; first tick CLK_HZ cycles after release.
